// File: rtl/counter_mod.sv
// -----------------------------------------------------------------------------
// counter_mod
//   Parametrised modulo up/down counter with parallel load, wrap/saturate
//   mode, an enable prescaler, a one-cycle terminal-count pulse and a sticky
//   wrap flag. All outputs are registered.
//
// Parameters
//   WIDTH     counter width in bits (1..32)
//   MODULUS   count range 0..MODULUS-1 (2..2**WIDTH)
//   PRESCALE  enabled cycles per count step (1..65535)
//
// Ports
//   clk         rising-edge clock
//   reset       synchronous active-low reset
//   enable      advances the prescaler when high
//   up          1 = count up, 0 = count down (sampled on every step)
//   saturate    1 = hold at the range ends, 0 = wrap modulo MODULUS
//   load        parallel load strobe (overrides enable)
//   load_value  value to load, clamped to MODULUS-1
//   out         current count
//   tc          terminal-count pulse, high while out shows the post-boundary value
//   wrapped     sticky: a boundary step happened since the last reset or load
// -----------------------------------------------------------------------------
module counter_mod #(
  parameter int unsigned     WIDTH    = 8,
  parameter longint unsigned MODULUS  = 64'd1 << WIDTH,
  parameter int unsigned     PRESCALE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             up,
  input  logic             saturate,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] out,
  output logic             tc,
  output logic             wrapped
);

  // Illegal parameter combinations stop elaboration.
  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $error("counter_mod: WIDTH must be 1..32");
  end
  if (MODULUS < 2 || MODULUS > (64'd1 << WIDTH)) begin : g_bad_modulus
    $error("counter_mod: MODULUS must be 2..2**WIDTH");
  end
  if (PRESCALE < 1 || PRESCALE > 65535) begin : g_bad_prescale
    $error("counter_mod: PRESCALE must be 1..65535");
  end

  localparam int unsigned      PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [WIDTH:0]   MOD_EXT  = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH-1:0] MAX_OUT  = WIDTH'(MODULUS - 64'd1);
  localparam logic [PW-1:0]    PRE_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0]    pre;

  logic [WIDTH:0]   cur_ext;
  logic [WIDTH:0]   inc_ext;
  logic [WIDTH:0]   dec_ext;
  logic [WIDTH:0]   load_ext;
  logic             at_top;
  logic             at_bottom;
  logic             boundary;
  logic [WIDTH-1:0] step_out;
  logic [WIDTH-1:0] load_out;

  // Next-value arithmetic carried one bit wider than the count, so the
  // top-of-range compare against MODULUS and the borrow out of zero both fall
  // out naturally, including when MODULUS == 2**WIDTH.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    step_out  = out;
    cur_ext   = {1'b0, out};
    inc_ext   = cur_ext + 1'b1;
    dec_ext   = cur_ext - 1'b1;
    load_ext  = {1'b0, load_value};
    at_top    = (inc_ext == MOD_EXT);
    at_bottom = dec_ext[WIDTH];           // borrow: out was 0
    boundary  = up ? at_top : at_bottom;

    if (!boundary) begin
      step_out = up ? inc_ext[WIDTH-1:0] : dec_ext[WIDTH-1:0];
    end else if (!saturate) begin
      step_out = up ? '0 : MAX_OUT;
    end

    load_out = (load_ext >= MOD_EXT) ? MAX_OUT : load_value;
  end

  // NOTE: all state uses non-blocking assignments so every register samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      out     <= '0;
      pre     <= '0;
      tc      <= 1'b0;
      wrapped <= 1'b0;
    end else if (load) begin
      out     <= load_out;
      pre     <= '0;
      tc      <= 1'b0;
      wrapped <= 1'b0;
    end else if (enable) begin
      if (pre == PRE_LAST) begin
        pre <= '0;
        out <= step_out;
        tc  <= boundary;
        if (boundary) begin
          wrapped <= 1'b1;
        end
      end else begin
        pre <= pre + 1'b1;
        tc  <= 1'b0;
      end
    end else begin
      tc <= 1'b0;
    end
  end

endmodule

// File: doc/counter_mod.md
# counter_mod

Parametrised modulo up/down counter; the next generation of the team's free-running 8-bit counter. It adds configurable width and modulus, count direction, parallel load, a wrap or saturate mode, an enable prescaler, a terminal-count pulse and a sticky wrap flag. It sits wherever the design needs a programmable event counter, timebase or cyclic index generator.

## Interface
- WIDTH, 8: counter width in bits (1..32).
- MODULUS, 2**WIDTH: count range 0..MODULUS-1. Legal range is 2..2**WIDTH; values outside it are a elaboration error.
- PRESCALE, 1: number of enabled cycles per count step (1..65535).

- clk  in  1  clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-low reset; sampled on the rising edge of clk.
- enable  in  1  count qualifier; advances the prescaler when high.
- up  in  1  direction: 1 counts up, 0 counts down; sampled on every step.
- saturate  in  1  mode: 1 saturates at the range ends, 0 wraps modulo MODULUS.
- load  in  1  parallel load strobe.
- load_value  in  WIDTH  value written when load is high.
- out  out  WIDTH  current count.
- tc  out  1  terminal-count pulse, one cycle wide.
- wrapped  out  1  sticky flag: a boundary was reached by a step since the last reset or load.

## Operation
- Internal prescaler phase register pre, range 0..PRESCALE-1, ceil(log2(PRESCALE)) bits, minimum 1 bit.
- Priority per rising edge, highest first: reset, load, step, hold.
- **reset low:** out=0, pre=0, tc=0, wrapped=0.
- **load high:** out=min(load_value, MODULUS-1), pre=0, tc=0, wrapped=0. enable is ignored that cycle.
- **enable high, pre<PRESCALE-1:** pre increments; out holds; tc=0.
- **enable high, pre==PRESCALE-1:** pre=0 and a step occurs.
- **enable low:** pre, out and wrapped hold; tc=0.
- **Step, up=1:**
  - out<MODULUS-1: out+1, tc=0.
  - out==MODULUS-1, wrap mode: out=0, tc=1, wrapped=1.
  - out==MODULUS-1, saturate mode: out holds at MODULUS-1, tc=1, wrapped=1.
- **Step, up=0:**
  - out>0: out-1, tc=0.
  - out==0, wrap mode: out=MODULUS-1, tc=1, wrapped=1.
  - out==0, saturate mode: out holds at 0, tc=1, wrapped=1.
- Saturate mode therefore repeats tc on every further step attempt at the boundary.
- **Arithmetic:**
  - Compute with one extra bit.
  - out never leaves 0..MODULUS-1, even when MODULUS<2**WIDTH.
  - For MODULUS==2**WIDTH, wrap equals natural binary overflow.
- up and saturate may change on any cycle; they take effect on the next step only. No state is kept per mode.

## Timing
- All outputs are registered; no combinational input-to-output path.
- Latency: inputs sampled at edge N appear on out, tc and wrapped after edge N.
- tc is high for exactly the one cycle in which out shows the post-boundary value.
- With PRESCALE=P and enable held high, a step occurs every P cycles. The first step after reset or load occurs on the P-th enabled edge.
- Reset mid-count takes effect on the next edge regardless of load or enable. The prescaler phase is lost.
- load together with a boundary step: load wins; tc=0 and wrapped=0.
- Reset values: out=0, tc=0, wrapped=0.

## Test plan
- WIDTH=4, MODULUS=10, PRESCALE=1, up=1, wrap mode, enable high for 12 cycles after reset -> out 1..9, 0, 1, 2. tc high only with out=0. wrapped goes high at that edge and stays high.
- Same configuration, up=0 from reset -> out 9, 8, …; tc high with out=9 on the first step, and again with out=9 ten steps later.
- saturate=1, up=1, load_value=8 then enable for 3 cycles -> out 9, 9, 9. tc sequence 0, 1, 1. wrapped=1. Switch up=0 -> out 8.
- PRESCALE=3, enable high 7 cycles then low 2 then high 2 -> out steps on enabled edges 3 and 6 only, holds while low, next step on enabled edge 9 (out=3).
- load_value=15 with MODULUS=10 -> out=9. load asserted on the same edge as a boundary step -> load value taken, tc=0, wrapped cleared.
- reset low while enable, load and a boundary step are all active -> out=0, tc=0, wrapped=0 on the next edge. Counting resumes from 0 one cycle after reset deasserts.
